// File: rtl/mips_md_pkg.sv
// Shared encodings for the MIPS multiply/divide unit: operation codes, default width, FSM states.
package mips_md_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    function automatic logic op_is_iter(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Combinational sign handling: operand magnitudes on entry, result negation at FIX.
// Zero latency; no flow control.
module md_sign_fix
    import mips_md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    output logic [WIDTH-1:0] o_mag_x,
    output logic [WIDTH-1:0] o_mag_y,
    output logic             o_neg_x,
    output logic             o_neg_y,
    input  logic             i_is_div,
    input  logic             i_neg_hi,
    input  logic             i_neg_lo,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_neg;

    assign o_neg_x = i_signed & i_x[WIDTH-1];
    assign o_neg_y = i_signed & i_y[WIDTH-1];
    assign o_mag_x = o_neg_x ? (~i_x + {{(WIDTH-1){1'b0}}, 1'b1}) : i_x;
    assign o_mag_y = o_neg_y ? (~i_y + {{(WIDTH-1){1'b0}}, 1'b1}) : i_y;

    assign w_prod     = {i_hi, i_lo};
    assign w_prod_neg = ~w_prod + {{(2*WIDTH-1){1'b0}}, 1'b1};

    // Products negate as one double-width value; quotient and remainder negate independently.
    always_comb begin
        o_hi = i_hi;
        o_lo = i_lo;
        if (!i_is_div) begin
            if (i_neg_lo) begin
                o_hi = w_prod_neg[2*WIDTH-1:WIDTH];
                o_lo = w_prod_neg[WIDTH-1:0];
            end
        end else begin
            if (i_neg_hi) o_hi = ~i_hi + {{(WIDTH-1){1'b0}}, 1'b1};
            if (i_neg_lo) o_lo = ~i_lo + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS mult/multu/div/divu plus mthi/mtlo, owning HI/LO; results and MDDone WIDTH+2 edges after start.
// Requests are accepted only while not busy; MDStart during RUN/FIX is dropped.
module mult_div_unit
    import mips_md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             MDStart,
    input  logic [2:0]       MDOp,
    input  logic [WIDTH-1:0] MDOpX,
    input  logic [WIDTH-1:0] MDOpY,
    output logic             MDBusy,
    output logic             MDDone,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_neg_hi;
    logic               r_neg_lo;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic [WIDTH-1:0]   w_mag_x;
    logic [WIDTH-1:0]   w_mag_y;
    logic               w_neg_x;
    logic               w_neg_y;
    logic               w_y_nz;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;
    logic [WIDTH-1:0]   w_res_hi;

    logic [WIDTH:0]     w_addend;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_acc;

    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_rem_next;
    logic [2*WIDTH-1:0] w_div_acc;

    assign w_y_nz   = |MDOpY;
    assign w_res_hi = r_is_div ? r_rem : r_acc[2*WIDTH-1:WIDTH];

    md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .i_signed (op_is_signed(MDOp)),
        .i_x      (MDOpX),
        .i_y      (MDOpY),
        .o_mag_x  (w_mag_x),
        .o_mag_y  (w_mag_y),
        .o_neg_x  (w_neg_x),
        .o_neg_y  (w_neg_y),
        .i_is_div (r_is_div),
        .i_neg_hi (r_neg_hi),
        .i_neg_lo (r_neg_lo),
        .i_hi     (w_res_hi),
        .i_lo     (r_acc[WIDTH-1:0]),
        .o_hi     (w_fix_hi),
        .o_lo     (w_fix_lo)
    );

    // Multiply: {partial product, multiplier}; add multiplicand on LSB, shift right one.
    assign w_addend  = r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}};
    assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + w_addend;
    assign w_mul_acc = {w_sum, r_acc[WIDTH-1:1]};

    // Restoring divide: dividend shifts out of the low half while quotient bits shift in.
    // A zero divisor never fails the trial subtract, giving an all-ones quotient and |X| remainder.
    assign w_shift    = {r_rem, r_acc[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_mcand};
    assign w_qbit     = ~w_diff[WIDTH];
    assign w_rem_next = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_div_acc  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], w_qbit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_hi <= 1'b0;
            r_neg_lo <= 1'b0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (MDStart) begin
                        if (op_is_iter(MDOp)) begin
                            r_state  <= ST_RUN;
                            r_cnt    <= CNT_LAST;
                            r_is_div <= MDOp[1];
                            r_rem    <= '0;
                            if (MDOp[1]) begin
                                r_acc    <= {{WIDTH{1'b0}}, w_mag_x};
                                r_mcand  <= w_mag_y;
                                // Divide-by-zero keeps an unsigned all-ones quotient and HI = X.
                                r_neg_lo <= (w_neg_x ^ w_neg_y) & w_y_nz;
                                r_neg_hi <= w_neg_x;
                            end else begin
                                r_acc    <= {{WIDTH{1'b0}}, w_mag_y};
                                r_mcand  <= w_mag_x;
                                r_neg_lo <= w_neg_x ^ w_neg_y;
                                r_neg_hi <= w_neg_x ^ w_neg_y;
                            end
                        end else if (MDOp == OP_MTHI) begin
                            r_hi <= MDOpX;
                        end else if (MDOp == OP_MTLO) begin
                            r_lo <= MDOpX;
                        end
                    end
                end
                ST_RUN: begin
                    if (r_is_div) begin
                        r_acc <= w_div_acc;
                        r_rem <= w_rem_next;
                    end else begin
                        r_acc <= w_mul_acc;
                    end
                    if (r_cnt == '0) begin
                        r_state <= ST_FIX;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign MDBusy = (r_state == ST_RUN) || (r_state == ST_FIX);
    assign MDDone = r_done;
    assign HI     = r_hi;
    assign LO     = r_lo;

endmodule
